multi_cycle_cpu: RTL and testbench
==================================

Name: multi_cycle_cpu

Overview:
- Parametrised multi-cycle MIPS-subset core; next generation of the single-cycle CPU top.
- Sequenced by an FSM: FETCH/DECODE/EXEC/MEM/WB.
- Contains the register file and ALU.
- Instruction and data memories are external, reached through req/ack handshakes, so wait-state memories work.

Parameters:
REG_NUM, 32, register-file depth (power of 2, 8..32); address width RAW=clog2(REG_NUM); register fields use the low RAW bits of rs/rt/rd.
IADDR_W, 8, instruction memory word-address width.
DADDR_W, 6, data memory word-address width.
RESET_PC, 32'h0, PC value loaded at reset (byte address).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request.
imem_addr  out  IADDR_W  = pc[IADDR_W+1:2].
imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  in  32  instruction word.
dmem_req  out  1  data access request.
dmem_we  out  1  1=store, 0=load.
dmem_addr  out  DADDR_W  = alu_result[DADDR_W+1:2] (upper bits ignored, wraps).
dmem_wdata  out  32  rt data for store.
dmem_ack  in  1  access complete; dmem_rdata valid for loads.
dmem_rdata  in  32  load data.
pc  out  32  current PC.
state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
ZF  out  1  registered zero flag of last ALU op.
OF  out  1  registered signed-overflow flag.
halted  out  1  high in HALT.
cycle_cnt  out  32  see Optional Feature.
instret_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=RESET_PC.
  - All registers=0.
  - IR, ZF, OF, halted, req outputs=0.
  - A reset mid-access drops req immediately; the pending ack is ignored.
- Handshake:
  - req is a registered output, raised on entry to FETCH/MEM.
  - Held with addr/wdata/we stable until a cycle with ack=1; the transfer completes in that cycle.
  - req deasserts next cycle.
  - ack while req=0 is ignored.
  - Zero-wait memory may assert ack in the first req cycle.
- Encoding is MIPS.
  - R-type (op 0), by funct: 20 add, 22 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt (signed), 04 sllv (rt<<rs[4:0]).
  - I-type, by op: 08 addi, 0C andi, 0D ori, 0E xori, 23 lw, 2B sw, 04 beq, 05 bne, 02 j, 3F halt.
  - Any other op/funct executes as NOP: no write, flags unchanged.
- Immediates: sign-extended for addi/lw/sw/beq/bne; zero-extended for andi/ori/xori.
- Register 0 reads as 0; writes to it are discarded.
- Write address: rd for R-type, rt for I-type.
- FSM transitions:
  - FETCH: on imem_ack, IR<=imem_rdata, pc<=pc+4 -> DECODE.
  - DECODE: latch A=R[rs], B=R[rt].
    - j: pc<={pc[31:28],IR[25:0],2'b00} -> FETCH.
    - halt -> HALT.
    - NOP -> FETCH.
    - Otherwise -> EXEC.
  - EXEC: compute ALU, latch result; ZF/OF update for ALU, lw/sw address and branch compares.
    - beq/bne: if taken, pc<=pc+(simm<<2) (pc already +4) -> FETCH.
    - lw/sw -> MEM.
    - ALU ops -> WB.
  - MEM: on dmem_ack, sw -> FETCH; lw latches dmem_rdata -> WB.
  - WB: register write (ALU result or load data) -> FETCH.
  - HALT: absorbing until reset; halted=1; no requests.
- Latency with zero-wait memory:
  - ALU: 4 cycles.
  - lw: 5; sw: 4.
  - beq/bne: 3; j and NOP: 2.
  - Each memory wait cycle adds 1.
- Arithmetic:
  - 32-bit two's complement; add/sub wrap.
  - OF = signed overflow of add/sub/addi, else 0. No trap.
  - ZF = (result==0).
- pc wraps at 2^32. imem_addr drops the upper PC bits.

Optional Feature:
- Macro: CPU_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every clock while not HALT.
  - instret_cnt increments on each instruction's final state exit: FETCH return after WB/MEM-store/EXEC-branch/DECODE-jump or NOP; halt entry counts once.
  - Both are 32-bit, wrap, and clear on reset.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Zero-wait memory, program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; halt` -> R3=2, ZF=0, OF=0, halted after 4+4+4+2 cycles, pc=0x10.
- `addi $1,$0,0x7FFF; sll` chain to 0x7FFFFFFF, then `add $2,$1,$1` -> R2=0xFFFFFFFE, OF=1; then `sub $3,$1,$1` -> R3=0, ZF=1, OF=0.
- `sw $1,8($0)` (R1=0xDEADBEEF) then `lw $4,8($0)` with dmem_ack delayed 3 cycles -> dmem_addr=2, dmem_req held 4 cycles each access, R4=0xDEADBEEF, lw total 8 cycles.
- `beq` taken with offset -2 and `bne` not taken -> pc follows target/fall-through; `j 0x40` -> pc=0x100; `addi $0,$0,7` -> R0 stays 0.
- reset pulsed low during MEM with dmem_req=1 -> dmem_req=0 immediately, pc=RESET_PC, state=0; late dmem_ack ignored. With CPU_PERF_CNT_EN, both counters read 0.
- Illegal op 0x3E -> NOP (2 cycles), flags unchanged; with CPU_PERF_CNT_EN, instret_cnt +1.

Source files
------------

// File: rtl/multi_cycle_cpu_if.sv
// Instruction and data memory req/ack buses of multi_cycle_cpu.
// The core drives the master modport; memories or bench models use the slave modport.
interface multi_cycle_cpu_if #(
   parameter int unsigned IADDR_W = 8,
   parameter int unsigned DADDR_W = 6
);
   logic               imem_req;
   logic [IADDR_W-1:0] imem_addr;
   logic               imem_ack;
   logic [31:0]        imem_rdata;
   logic               dmem_req;
   logic               dmem_we;
   logic [DADDR_W-1:0] dmem_addr;
   logic [31:0]        dmem_wdata;
   logic               dmem_ack;
   logic [31:0]        dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM with req/ack memory buses.
// Define CPU_PERF_CNT_EN to build the cycle and retired-instruction counters.
module multi_cycle_cpu #(
   parameter int unsigned REG_NUM  = 32,
   parameter int unsigned IADDR_W  = 8,
   parameter int unsigned DADDR_W  = 6,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   multi_cycle_cpu_if.master        bus,
   output logic [31:0]              pc,
   output logic [2:0]               state,
   output logic                     ZF,
   output logic                     OF,
   output logic                     halted,
   output logic [31:0]              cycle_cnt,
   output logic [31:0]              instret_cnt
);

   localparam int unsigned RAW = $clog2(REG_NUM);

   localparam logic [5:0] OpR    = 6'h00;
   localparam logic [5:0] OpAddi = 6'h08;
   localparam logic [5:0] OpAndi = 6'h0C;
   localparam logic [5:0] OpOri  = 6'h0D;
   localparam logic [5:0] OpXori = 6'h0E;
   localparam logic [5:0] OpLw   = 6'h23;
   localparam logic [5:0] OpSw   = 6'h2B;
   localparam logic [5:0] OpBeq  = 6'h04;
   localparam logic [5:0] OpBne  = 6'h05;
   localparam logic [5:0] OpJ    = 6'h02;
   localparam logic [5:0] OpHalt = 6'h3F;

   localparam logic [5:0] FnAdd  = 6'h20;
   localparam logic [5:0] FnSub  = 6'h22;
   localparam logic [5:0] FnAnd  = 6'h24;
   localparam logic [5:0] FnOr   = 6'h25;
   localparam logic [5:0] FnXor  = 6'h26;
   localparam logic [5:0] FnNor  = 6'h27;
   localparam logic [5:0] FnSlt  = 6'h2A;
   localparam logic [5:0] FnSllv = 6'h04;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   state_e state_q, state_d;
   logic   imem_req_q, imem_req_d;
   logic   dmem_req_q, dmem_req_d;

   logic [31:0] pc_q, ir_q, a_q, b_q, res_q, mdr_q;
   logic        zf_q, of_q;
   logic [31:0] rf_q [REG_NUM];

   // Instruction fields and classification
   logic [5:0]     op, funct;
   logic [RAW-1:0] rs_a, rt_a, rd_a, wr_addr;
   logic [31:0]    simm, zimm;
   logic           is_rtype, is_zext, is_alu_i, is_lw, is_sw, is_branch, is_exec;

   assign op    = ir_q[31:26];
   assign funct = ir_q[5:0];
   assign rs_a  = ir_q[21 +: RAW];
   assign rt_a  = ir_q[16 +: RAW];
   assign rd_a  = ir_q[11 +: RAW];
   assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};
   assign zimm  = {16'h0000, ir_q[15:0]};

   assign is_rtype  = (op == OpR) &&
                      (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnXor, FnNor, FnSlt, FnSllv});
   assign is_zext   = op inside {OpAndi, OpOri, OpXori};
   assign is_alu_i  = is_zext || (op == OpAddi);
   assign is_lw     = (op == OpLw);
   assign is_sw     = (op == OpSw);
   assign is_branch = (op == OpBeq) || (op == OpBne);
   assign is_exec   = is_rtype || is_alu_i || is_lw || is_sw || is_branch;
   assign wr_addr   = (op == OpR) ? rd_a : rt_a;

   logic fetch_done, mem_done, br_taken;
   assign fetch_done = imem_req_q && bus.imem_ack;
   assign mem_done   = dmem_req_q && bus.dmem_ack;
   assign br_taken   = (op == OpBeq) ? (a_q == b_q) : (a_q != b_q);

   // ALU
   logic [31:0] opnd_b, sum_w, diff_w, alu_res;
   logic        add_of, sub_of, alu_of;

   always_comb begin
      opnd_b  = is_zext ? zimm : ((op == OpR) || is_branch) ? b_q : simm;
      sum_w   = a_q + opnd_b;
      diff_w  = a_q - opnd_b;
      add_of  = (a_q[31] == opnd_b[31]) && (sum_w[31] != a_q[31]);
      sub_of  = (a_q[31] != opnd_b[31]) && (diff_w[31] != a_q[31]);
      alu_res = '0;
      alu_of  = 1'b0;
      case (op)
         OpR: begin
            case (funct)
               FnAdd:   begin alu_res = sum_w;  alu_of = add_of; end
               FnSub:   begin alu_res = diff_w; alu_of = sub_of; end
               FnAnd:   alu_res = a_q & b_q;
               FnOr:    alu_res = a_q | b_q;
               FnXor:   alu_res = a_q ^ b_q;
               FnNor:   alu_res = ~(a_q | b_q);
               FnSlt:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
               FnSllv:  alu_res = b_q << a_q[4:0];
               default: alu_res = '0;
            endcase
         end
         OpAddi:       begin alu_res = sum_w; alu_of = add_of; end
         OpAndi:       alu_res = a_q & zimm;
         OpOri:        alu_res = a_q | zimm;
         OpXori:       alu_res = a_q ^ zimm;
         OpLw, OpSw:   alu_res = sum_w;
         OpBeq, OpBne: alu_res = diff_w;
         default:      alu_res = '0;
      endcase
   end

   // FSM state register; req outputs are registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StFetch;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         imem_req_q <= imem_req_d;
         dmem_req_q <= dmem_req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:  if (fetch_done) state_d = StDecode;
         StDecode: begin
            if (op == OpJ)        state_d = StFetch;
            else if (op == OpHalt) state_d = StHalt;
            else if (is_exec)      state_d = StExec;
            else                   state_d = StFetch;
         end
         StExec: begin
            if (is_lw || is_sw)  state_d = StMem;
            else if (is_branch)  state_d = StFetch;
            else                 state_d = StWb;
         end
         StMem:    if (mem_done) state_d = is_sw ? StFetch : StWb;
         StWb:     state_d = StFetch;
         StHalt:   state_d = StHalt;
         default:  state_d = StFetch;
      endcase
   end

   // Right after reset FETCH is entered with req low, so it spends one cycle raising it.
   always_comb begin
      imem_req_d = (state_d == StFetch);
      dmem_req_d = (state_d == StMem);
   end

   // Datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC;
         ir_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         mdr_q <= '0;
         zf_q  <= 1'b0;
         of_q  <= 1'b0;
         for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
      end else begin
         case (state_q)
            StFetch: begin
               if (fetch_done) begin
                  ir_q <= bus.imem_rdata;
                  pc_q <= pc_q + 32'd4;
               end
            end
            StDecode: begin
               a_q <= rf_q[rs_a];
               b_q <= rf_q[rt_a];
               if (op == OpJ) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            end
            StExec: begin
               res_q <= alu_res;
               zf_q  <= (alu_res == 32'h0);
               of_q  <= alu_of;
               if (is_branch && br_taken) pc_q <= pc_q + {simm[29:0], 2'b00};
            end
            StMem: begin
               if (mem_done && is_lw) mdr_q <= bus.dmem_rdata;
            end
            StWb: begin
               if (wr_addr != '0) rf_q[wr_addr] <= is_lw ? mdr_q : res_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = pc_q[IADDR_W+1:2];
   assign bus.dmem_req   = dmem_req_q;
   assign bus.dmem_we    = is_sw;
   assign bus.dmem_addr  = res_q[DADDR_W+1:2];
   assign bus.dmem_wdata = b_q;

   assign pc     = pc_q;
   assign state  = state_q;
   assign ZF     = zf_q;
   assign OF     = of_q;
   assign halted = (state_q == StHalt);

`ifdef CPU_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instret_cnt_q;
   logic        retire;

   // An instruction retires when control returns to FETCH or enters HALT.
   assign retire = ((state_q != StFetch) && (state_d == StFetch)) ||
                   ((state_q != StHalt) && (state_d == StHalt));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         if (state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (retire) instret_cnt_q <= instret_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu with zero-wait instruction memory and a delayable data memory.
module tb_multi_cycle_cpu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc, cycle_cnt, instret_cnt;
   logic [2:0]  state;
   logic        zf, of, halted;
   int          checks = 0;
   int          errors = 0;

   multi_cycle_cpu_if #(.IADDR_W(8), .DADDR_W(6)) bus ();

   multi_cycle_cpu u_dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .pc          (pc),
      .state       (state),
      .ZF          (zf),
      .OF          (of),
      .halted      (halted),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

   always #5 clk = ~clk;

   // Memory models
   logic [31:0] imem [256];
   logic [31:0] dmem [64];
   int          dmem_dly = 0;
   int          dcnt = 0;
   logic        force_dack = 1'b0;
   int          dreq_cyc = 0;
   int          daddr_bad = 0;

   assign bus.imem_ack   = bus.imem_req;
   assign bus.imem_rdata = imem[bus.imem_addr];
   assign bus.dmem_ack   = (bus.dmem_req && (dcnt == dmem_dly)) || force_dack;
   assign bus.dmem_rdata = dmem[bus.dmem_addr];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dcnt <= 0;
         for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
      end else begin
         if (!bus.dmem_req || bus.dmem_ack) dcnt <= 0;
         else dcnt <= dcnt + 1;
         if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
      end
   end

   always @(negedge clk) begin
      if (reset && bus.dmem_req) begin
         dreq_cyc <= dreq_cyc + 1;
         if (bus.dmem_addr != 6'd2) daddr_bad <= daddr_bad + 1;
      end
   end

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
      logic [4:0] s, t, d;
      s = rs[4:0];
      t = rt[4:0];
      d = rd[4:0];
      return {6'h00, s, t, d, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
      logic [4:0] s, t;
      s = rs[4:0];
      t = rt[4:0];
      return {op, s, t, imm};
   endfunction

   localparam logic [31:0] Halt = 32'hFC00_0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic hold_reset();
      reset = 1'b0;
      force_dack = 1'b0;
      dmem_dly = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
   endtask

   // Latency is counted from the first cycle the fetch request is visible.
   task automatic run_prog(output int cyc);
      int guard;
      cyc = 0;
      guard = 0;
      @(negedge clk) reset = 1'b1;
      while (!bus.imem_req && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      while (!halted && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   int cyc, snap_req, snap_bad, guard;

   initial begin
      // Reset values
      #2 reset = 1'b0;
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_state", {29'b0, state}, 32'd0);
      check("rst_flags_halt", {29'b0, zf, of, halted}, 32'd0);
      check("rst_reqs", {30'b0, bus.imem_req, bus.dmem_req}, 32'd0);

      // Program 1: basic ALU and halt
      hold_reset();
      imem[0] = enc_i(6'h08, 0, 1, 16'd5);
      imem[1] = enc_i(6'h08, 0, 2, 16'hFFFD);
      imem[2] = enc_r(1, 2, 3, 6'h20);
      imem[3] = Halt;
      run_prog(cyc);
      check("p1_cycles", cyc, 32'd14);
      check("p1_halted", {31'b0, halted}, 32'd1);
      check("p1_state", {29'b0, state}, 32'd5);
      check("p1_r3", u_dut.rf_q[3], 32'd2);
      check("p1_flags", {30'b0, zf, of}, 32'd0);
      check("p1_pc", pc, 32'h10);
      check("p1_no_req", {30'b0, bus.imem_req, bus.dmem_req}, 32'd0);
`ifdef CPU_PERF_CNT_EN
      check("p1_cycle_cnt", cycle_cnt, 32'd15);
      check("p1_instret", instret_cnt, 32'd4);
`else
      check("p1_cnt_tied", cycle_cnt | instret_cnt, 32'd0);
`endif

      // Program 2a: build 0x7FFFFFFF, signed overflow on add
      hold_reset();
      imem[0] = enc_i(6'h08, 0, 1, 16'h7FFF);
      imem[1] = enc_i(6'h08, 0, 5, 16'd16);
      imem[2] = enc_r(5, 1, 1, 6'h04);
      imem[3] = enc_i(6'h0D, 1, 1, 16'hFFFF);
      imem[4] = enc_r(1, 1, 2, 6'h20);
      imem[5] = Halt;
      run_prog(cyc);
      check("p2a_cycles", cyc, 32'd22);
      check("p2a_r1", u_dut.rf_q[1], 32'h7FFF_FFFF);
      check("p2a_r2", u_dut.rf_q[2], 32'hFFFF_FFFE);
      check("p2a_zf_of", {30'b0, zf, of}, 32'b01);

      // Program 2b: same prefix, then sub to zero
      hold_reset();
      imem[0] = enc_i(6'h08, 0, 1, 16'h7FFF);
      imem[1] = enc_i(6'h08, 0, 5, 16'd16);
      imem[2] = enc_r(5, 1, 1, 6'h04);
      imem[3] = enc_i(6'h0D, 1, 1, 16'hFFFF);
      imem[4] = enc_r(1, 1, 2, 6'h20);
      imem[5] = enc_r(1, 1, 3, 6'h22);
      imem[6] = Halt;
      run_prog(cyc);
      check("p2b_r3", u_dut.rf_q[3], 32'h0);
      check("p2b_zf_of", {30'b0, zf, of}, 32'b10);

      // Program 3: store/load with 3 data wait cycles
      hold_reset();
      dmem_dly = 3;
      imem[0] = enc_i(6'h0D, 0, 1, 16'hDEAD);
      imem[1] = enc_i(6'h08, 0, 5, 16'd16);
      imem[2] = enc_r(5, 1, 1, 6'h04);
      imem[3] = enc_i(6'h0D, 1, 1, 16'hBEEF);
      imem[4] = enc_i(6'h2B, 0, 1, 16'd8);
      imem[5] = enc_i(6'h23, 0, 4, 16'd8);
      imem[6] = Halt;
      snap_req = dreq_cyc;
      snap_bad = daddr_bad;
      run_prog(cyc);
      check("p3_cycles", cyc, 32'd33);
      check("p3_req_cycles", dreq_cyc - snap_req, 32'd8);
      check("p3_addr_bad", daddr_bad - snap_bad, 32'd0);
      check("p3_dmem2", dmem[2], 32'hDEAD_BEEF);
      check("p3_r4", u_dut.rf_q[4], 32'hDEAD_BEEF);

      // Program 4: r0 write, jump, taken beq backwards, untaken bne
      hold_reset();
      imem[0]  = enc_i(6'h08, 0, 0, 16'd7);
      imem[1]  = enc_i(6'h08, 0, 1, 16'd1);
      imem[2]  = {6'h02, 26'h40};
      imem[64] = enc_i(6'h08, 0, 3, 16'd0);
      imem[65] = enc_i(6'h08, 3, 3, 16'd1);
      imem[66] = enc_i(6'h04, 3, 1, 16'hFFFE);
      imem[67] = enc_i(6'h05, 0, 0, 16'd5);
      imem[68] = Halt;
      imem[73] = Halt;
      run_prog(cyc);
      check("p4_cycles", cyc, 32'd33);
      check("p4_pc", pc, 32'h114);
      check("p4_r0", u_dut.rf_q[0], 32'h0);
      check("p4_r3", u_dut.rf_q[3], 32'd2);
      check("p4_zf_of", {30'b0, zf, of}, 32'b10);

      // Program 5: reset in the middle of a store access
      hold_reset();
      dmem_dly = 10;
      imem[0] = enc_i(6'h08, 0, 1, 16'd9);
      imem[1] = enc_i(6'h2B, 0, 1, 16'd4);
      imem[2] = Halt;
      @(negedge clk) reset = 1'b1;
      guard = 0;
      while (!bus.dmem_req && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("p5_req_seen", {31'b0, bus.dmem_req}, 32'd1);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("p5_req_drop", {31'b0, bus.dmem_req}, 32'd0);
      check("p5_pc", pc, 32'h0);
      check("p5_state", {29'b0, state}, 32'd0);
`ifdef CPU_PERF_CNT_EN
      check("p5_counters", cycle_cnt | instret_cnt, 32'd0);
`endif
      force_dack = 1'b1;
      dmem_dly = 0;
      repeat (2) @(negedge clk);
      run_prog(cyc);
      force_dack = 1'b0;
      check("p5_cycles", cyc, 32'd10);
      check("p5_dmem1", dmem[1], 32'd9);
      check("p5_pc_end", pc, 32'hC);

      // Program 6: illegal opcode and unknown funct run as NOPs
      hold_reset();
      imem[0] = enc_r(0, 0, 3, 6'h22);
      imem[1] = 32'hF800_0000;
      imem[2] = enc_r(1, 1, 2, 6'h21);
      imem[3] = Halt;
      run_prog(cyc);
      check("p6_cycles", cyc, 32'd10);
      check("p6_zf_of", {30'b0, zf, of}, 32'b10);
      check("p6_r2", u_dut.rf_q[2], 32'h0);
      check("p6_pc", pc, 32'h10);
`ifdef CPU_PERF_CNT_EN
      check("p6_cycle_cnt", cycle_cnt, 32'd11);
      check("p6_instret", instret_cnt, 32'd4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
